regbank_regfile: RTL and testbench

//   Register-bank storage array: consumes the one-hot write-enable vector from the

---
 rtl/regbank_if.sv | 22 ++
 rtl/regbank_regfile.sv | 34 +++
 tb/tb_regbank_regfile.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/regbank_if.sv
// regbank_if: write-enable/data, dual read-address and read-data bundle for the register bank
interface regbank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
);
  logic [NREGS-1:0]  we_onehot;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              multi_we_err;
  modport master (
    output we_onehot, wr_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, multi_we_err
  );
  modport slave (
    input  we_onehot, wr_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, multi_we_err
  );
endinterface

// File: rtl/regbank_regfile.sv
// regbank_regfile: one-hot-written register array with two registered bypassing read ports
module regbank_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREGS    = 32,
  parameter bit ZERO_REG = 1
) (
  input logic clk,
  input logic rst,
  regbank_if.slave bus
);
  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  wmask;
  logic              illegal;
  // x & (x-1) is nonzero exactly when two or more enables are high
  always_comb begin
    illegal = |(bus.we_onehot & (bus.we_onehot - NREGS'(1)));
    wmask   = illegal ? '0 : bus.we_onehot & ~NREGS'(ZERO_REG);
  end
  // With ZERO_REG, regs[0] is never written, so it reads as zero without a special case
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      bus.rd_data_a    <= '0;
      bus.rd_data_b    <= '0;
      bus.multi_we_err <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) if (wmask[i]) regs[i] <= bus.wr_data;
      bus.rd_data_a <= wmask[bus.rd_addr_a] ? bus.wr_data : regs[bus.rd_addr_a];
      bus.rd_data_b <= wmask[bus.rd_addr_b] ? bus.wr_data : regs[bus.rd_addr_b];
      if (illegal) bus.multi_we_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regbank_regfile.sv
// tb_regbank_regfile: directed and randomized checks of regbank_regfile against an array model
module tb_regbank_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails  = 0;
  logic [31:0] mem [32];
  logic        merr;
  logic [31:0] exp_a, exp_b;
  regbank_if bus ();
  regbank_regfile dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic [31:0] we, input logic [31:0] d,
                       input logic [4:0] aa, input logic [4:0] ab);
    int n;
    rst = r;
    bus.we_onehot = we;
    bus.wr_data = d;
    bus.rd_addr_a = aa;
    bus.rd_addr_b = ab;
    n = $countones(we);
    if (r) begin
      exp_a = 0;
      exp_b = 0;
      merr = 0;
      for (int i = 0; i < 32; i++) mem[i] = 0;
    end else begin
      exp_a = (aa == 0) ? 32'h0 : (n == 1 && we[aa]) ? d : mem[aa];
      exp_b = (ab == 0) ? 32'h0 : (n == 1 && we[ab]) ? d : mem[ab];
      if (n == 1 && !we[0]) mem[$clog2(we)] = d;
      if (n > 1) merr = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 20; i++) drive(0, 32'h1 << $urandom_range(31), $urandom, 5'($urandom), 5'($urandom));
    drive(1, 32'h1 << 3, 32'h77, 3, 3);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 5'(i), 5'(31 - i));
      checks++;
      if (bus.rd_data_a !== 32'h0) begin fails++; $display("FAIL reset_rd_a addr=%0d got=%h exp=0", i, bus.rd_data_a); end
      checks++;
      if (bus.rd_data_b !== 32'h0) begin fails++; $display("FAIL reset_rd_b addr=%0d got=%h exp=0", 31 - i, bus.rd_data_b); end
    end
    checks++;
    if (bus.multi_we_err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", bus.multi_we_err); end
  endtask

  task automatic test_write_read;
    drive(0, 32'h1 << 5, 32'hDEADBEEF, 0, 0);
    drive(0, 0, 0, 5, 4);
    checks++;
    if (bus.rd_data_a !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_rd_5 got=%h exp=deadbeef", bus.rd_data_a); end
    checks++;
    if (bus.rd_data_b !== 32'h0) begin fails++; $display("FAIL wr_rd_4 got=%h exp=0", bus.rd_data_b); end
    drive(0, 0, 0, 5, 6);
    checks++;
    if (bus.rd_data_b !== 32'h0) begin fails++; $display("FAIL wr_rd_6 got=%h exp=0", bus.rd_data_b); end
  endtask

  task automatic test_bypass;
    drive(0, 32'h1 << 9, 32'h1111_0000, 0, 0);
    drive(0, 32'h1 << 9, 32'h12345678, 9, 9);
    checks++;
    if (bus.rd_data_b !== 32'h12345678) begin fails++; $display("FAIL bypass_b got=%h exp=12345678", bus.rd_data_b); end
    checks++;
    if (bus.rd_data_a !== bus.rd_data_b || bus.rd_data_a !== exp_a) begin
      fails++; $display("FAIL bypass_a got=%h exp=%h", bus.rd_data_a, exp_a);
    end
  endtask

  task automatic test_zero_reg;
    drive(0, 32'h1, 32'hFFFFFFFF, 0, 0);
    checks++;
    if (bus.rd_data_a !== 32'h0 || bus.rd_data_b !== 32'h0) begin
      fails++; $display("FAIL zero_same a=%h b=%h exp=0", bus.rd_data_a, bus.rd_data_b);
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (bus.rd_data_a !== 32'h0) begin fails++; $display("FAIL zero_next got=%h exp=0", bus.rd_data_a); end
    checks++;
    if (bus.multi_we_err !== 1'b0) begin fails++; $display("FAIL zero_err got=%b exp=0", bus.multi_we_err); end
  endtask

  task automatic test_illegal;
    drive(0, 32'h1 << 3, 32'hA, 0, 0);
    drive(0, 32'h1 << 7, 32'hB, 0, 0);
    drive(0, (32'h1 << 3) | (32'h1 << 7), 32'hC, 3, 7);
    checks++;
    if (bus.rd_data_a !== 32'hA || bus.rd_data_b !== 32'hB) begin
      fails++; $display("FAIL illegal_nobypass a=%h b=%h exp=a/b", bus.rd_data_a, bus.rd_data_b);
    end
    checks++;
    if (bus.multi_we_err !== 1'b1) begin fails++; $display("FAIL illegal_err got=%b exp=1", bus.multi_we_err); end
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 3, 7);
    checks++;
    if (bus.rd_data_a !== 32'hA || bus.rd_data_b !== 32'hB) begin
      fails++; $display("FAIL illegal_kept a=%h b=%h exp=a/b", bus.rd_data_a, bus.rd_data_b);
    end
    checks++;
    if (bus.multi_we_err !== 1'b1) begin fails++; $display("FAIL illegal_sticky got=%b exp=1", bus.multi_we_err); end
    drive(1, 0, 0, 0, 0);
    checks++;
    if (bus.multi_we_err !== 1'b0) begin fails++; $display("FAIL illegal_clear got=%b exp=0", bus.multi_we_err); end
  endtask

  task automatic test_reset_priority;
    drive(0, 32'h1 << 12, 32'h99, 0, 0);
    drive(1, 32'h1 << 12, 32'h55, 12, 12);
    checks++;
    if (bus.rd_data_a !== 32'h0) begin fails++; $display("FAIL rstpri_during got=%h exp=0", bus.rd_data_a); end
    drive(0, 0, 0, 12, 12);
    checks++;
    if (bus.rd_data_a !== 32'h0 || bus.rd_data_b !== 32'h0) begin
      fails++; $display("FAIL rstpri_after a=%h b=%h exp=0", bus.rd_data_a, bus.rd_data_b);
    end
  endtask

  task automatic test_random;
    logic [31:0] we;
    int k;
    for (int c = 0; c < 400; c++) begin
      k = $urandom_range(99);
      we = (k < 15) ? 32'h0 : (k < 20) ? $urandom | (32'h1 << $urandom_range(31)) | 32'h3 : 32'h1 << $urandom_range(31);
      drive(k == 99, we, $urandom, 5'($urandom), 5'($urandom));
      checks++;
      if (bus.rd_data_a !== exp_a || bus.rd_data_b !== exp_b || bus.multi_we_err !== merr) begin
        fails++;
        $display("FAIL random cyc=%0d a=%h/%h b=%h/%h err=%b/%b (got/exp)", c, bus.rd_data_a, exp_a,
                 bus.rd_data_b, exp_b, bus.multi_we_err, merr);
      end
    end
  endtask

  initial begin
    bus.we_onehot = 0;
    bus.wr_data = 0;
    bus.rd_addr_a = 0;
    bus.rd_addr_b = 0;
    @(negedge clk);
    drive(1, 0, 0, 0, 0);
    test_reset;
    test_write_read;
    test_bypass;
    test_zero_reg;
    test_illegal;
    test_reset_priority;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
